// File: rtl/vga_sync_if.sv
// vga_sync_if: raster timing bundle between the VGA sync generator and the
// board renderer.
//   master : the timing generator (takes pixel/blink ticks, drives timing)
//   slave  : the consumer side (supplies ticks, receives timing)
// Signals:
//   pix_en      - one-clk 25 MHz pixel tick
//   blink_tick  - one-clk 4 Hz cursor blink pulse
//   hcount      - pixel column, 0..H_TOTAL-1
//   vcount      - line, 0..V_TOTAL-1
//   hsync/vsync - active-low sync
//   video_on    - visible-area flag
//   line_start  - one-clk pulse after hcount wraps to 0
//   frame_start - one-clk pulse after (hcount,vcount) wraps to (0,0)
//   blink_phase - cursor visibility phase, changes only at frame start
interface vga_sync_if;
  logic       pix_en;
  logic       blink_tick;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       hsync;
  logic       vsync;
  logic       video_on;
  logic       line_start;
  logic       frame_start;
  logic       blink_phase;

  modport master (
    input  pix_en, blink_tick,
    output hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, blink_phase
  );

  modport slave (
    output pix_en, blink_tick,
    input  hcount, vcount, hsync, vsync, video_on,
           line_start, frame_start, blink_phase
  );
endinterface

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480@60 Hz VGA raster timing generator. Runs on the
// 100 MHz clock and advances the raster only on pix_en. Sync, blanking and
// line/frame pulses are registered on the same edge as the counters, so
// they always describe the hcount/vcount presented alongside them.
// Ports:
//   clk  - 100 MHz master clock
//   rst  - synchronous, active-high reset
//   vif  - vga_sync_if.master (pix_en/blink_tick in, timing out)
// Build option:
//   VGA_BLINK_SYNC_EN - when defined, blink_tick is re-timed to frame
//   boundaries into blink_phase; otherwise blink_phase is tied to 0.
// Timing values are parameters so the raster can be shrunk for simulation;
// both totals must stay <= 1024 to fit the 10-bit counters.
module vga_sync_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input logic        clk,
  input logic        rst,
  vga_sync_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_MAX     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS     = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS     = 10'(V_ACTIVE);
  localparam logic [9:0] HS_FIRST  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] hcount_q, vcount_q;
  logic [9:0] hcount_nxt, vcount_nxt;
  logic       hsync_q, vsync_q, video_on_q;
  logic       line_start_q, frame_start_q;
  logic       blink_phase_q;
  logic       h_last, v_last, frame_wrap;

  assign h_last     = (hcount_q == H_MAX);
  assign v_last     = (vcount_q == V_MAX);
  assign frame_wrap = vif.pix_en && h_last && v_last;

  // Next raster position; the decodes below look at these so the registered
  // flags line up with the counters they are registered alongside.
  always_comb begin
    hcount_nxt = hcount_q + 10'd1;
    vcount_nxt = vcount_q;
    if (h_last) begin
      hcount_nxt = 10'd0;
      vcount_nxt = v_last ? 10'd0 : vcount_q + 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_q      <= H_MAX;
      vcount_q      <= V_MAX;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      video_on_q    <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else if (vif.pix_en) begin
      hcount_q      <= hcount_nxt;
      vcount_q      <= vcount_nxt;
      hsync_q       <= !(hcount_nxt >= HS_FIRST && hcount_nxt <= HS_LAST);
      vsync_q       <= !(vcount_nxt >= VS_FIRST && vcount_nxt <= VS_LAST);
      video_on_q    <= (hcount_nxt < H_VIS) && (vcount_nxt < V_VIS);
      line_start_q  <= h_last;
      frame_start_q <= h_last && v_last;
    end else begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

`ifdef VGA_BLINK_SYNC_EN
  logic blink_pend_q;

  // A tick landing on the wrap edge itself counts for the frame that starts
  // there, so it toggles immediately instead of waiting a whole frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_pend_q  <= 1'b0;
      blink_phase_q <= 1'b0;
    end else if (frame_wrap) begin
      blink_pend_q  <= 1'b0;
      blink_phase_q <= blink_phase_q ^ (blink_pend_q | vif.blink_tick);
    end else if (vif.blink_tick) begin
      blink_pend_q  <= 1'b1;
    end
  end
`else
  logic unused_blink;
  assign unused_blink  = vif.blink_tick ^ frame_wrap;
  assign blink_phase_q = 1'b0;
`endif

  assign vif.hcount      = hcount_q;
  assign vif.vcount      = vcount_q;
  assign vif.hsync       = hsync_q;
  assign vif.vsync       = vsync_q;
  assign vif.video_on    = video_on_q;
  assign vif.line_start  = line_start_q;
  assign vif.frame_start = frame_start_q;
  assign vif.blink_phase = blink_phase_q;

endmodule

// File: doc/vga_sync_gen.md
# vga_sync_gen

VGA 640x480@60 Hz raster timing generator for the Minesweeper display path. It runs on the 100 MHz master clock. It advances its horizontal and vertical counters only on the 25 MHz pixel-enable pulse from the clock divider, and produces sync, blanking and pixel coordinates for the board renderer. It also re-times the 4 Hz cursor-blink pulse to frame boundaries so the cursor never tears mid-frame.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- clk  in  1  100 MHz master clock
- rst  in  1  reset: synchronous, active-high
- pix_en  in  1  one-clk pulse; 25 MHz pixel tick (1 of every 4 clk)
- blink_tick  in  1  one-clk pulse at 4 Hz
- hcount  out  10  current pixel column, 0..H_TOTAL-1
- vcount  out  10  current line, 0..V_TOTAL-1
- hsync  out  1  horizontal sync, active-low
- vsync  out  1  vertical sync, active-low
- video_on  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE
- line_start  out  1  one-clk pulse when hcount wraps to 0
- frame_start  out  1  one-clk pulse when (hcount,vcount) wraps to (0,0)
- blink_phase  out  1  cursor visibility phase, constant within a frame

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525). Both totals must be ≤1024.
- On a clk edge with pix_en=1:
  - hcount increments. At H_TOTAL-1 it wraps to 0 and vcount increments.
  - vcount wraps from V_TOTAL-1 to 0 on the same edge that hcount wraps.
- On a clk edge with pix_en=0, all counters and sync outputs hold.
- Decode thresholds:
  - hsync=0 iff H_ACTIVE+H_FP ≤ hcount ≤ H_ACTIVE+H_FP+H_SYNC-1 (656..751).
  - vsync=0 iff V_ACTIVE+V_FP ≤ vcount ≤ V_ACTIVE+V_FP+V_SYNC-1 (490..491).
- hsync, vsync and video_on are registered. They are computed from the next counter values, so they always match the hcount/vcount presented in the same cycle.
- line_start is high for exactly one clk after the pix_en edge that wraps hcount to 0. frame_start additionally requires vcount to wrap to 0. Both pulses are 0 on every other clk.
- Blink re-timing (see Configuration):
  - A blink_tick sets a pending flag.
  - On the frame_start edge, blink_phase toggles if the flag is set or if blink_tick is high on that same cycle, and the flag clears.
  - Multiple ticks within one frame produce one toggle.

## Timing
- Reset state:
  - Counters: hcount=H_TOTAL-1 (799), vcount=V_TOTAL-1 (524).
  - Outputs: hsync=1, vsync=1, video_on=0, line_start=0, frame_start=0, blink_phase=0; pending flag=0.
- The first pix_en after reset moves the counters to (0,0), asserts line_start and frame_start for one clk, and sets video_on=1.
- rst overrides pix_en and blink_tick on the same edge. rst asserted mid-frame returns the block to the reset state on the next edge.
- Latency from a pix_en edge to updated hcount, vcount, sync and video_on is 0 extra cycles: all are registered on the same edge.
- pix_en held continuously high (simulation use) advances the raster every clk. Behaviour stays otherwise identical.
- Line period is H_TOTAL pix_en pulses. Frame period is H_TOTAL*V_TOTAL pix_en pulses (420000).

## Configuration
- VGA_BLINK_SYNC_EN defined: blink re-timing logic is present as described above.
- VGA_BLINK_SYNC_EN undefined:
  - The pending flag and toggle logic are removed.
  - blink_phase is tied to 0 and blink_tick is ignored.
  - All other outputs are unchanged.

## Test plan
- Reset, then one pix_en → (hcount,vcount)=(0,0), line_start=frame_start=1 for one clk, video_on=1, hsync=vsync=1.
- Advance 656 pix_en from (0,0) → hcount=656, hsync=0. At hcount=752, hsync=1. At hcount=640, video_on=0.
- Advance 800 pix_en from (0,0) → hcount=0, vcount=1, line_start pulse with no frame_start. Run to vcount=490 → vsync=0 for lines 490-491 only.
- Full frame of 420000 pix_en → exactly one frame_start and 525 line_start pulses; counters back at (0,0).
- blink_tick at vcount=100, again at vcount=200 → blink_phase toggles 0→1 once, exactly at the next frame_start. blink_tick coincident with frame_start → toggles on that edge. Macro undefined → blink_phase stays 0.
- Assert rst at (300,200) with pix_en=1 → next cycle shows (799,524), hsync=vsync=1, video_on=0, blink_phase=0.
